net_cmd_unit: RTL

Parametrised network command front end for a core: accepts packets addressed to this core, buffers them in an in-order FIFO, and retires them as instruction-memory writes, register-file writes, barrier-mask updates or PC-start commands. Owns the core run state (IDLE/RUN/ERR), the barrier mask and the sticky exception flag. Replaces the single-entry, stall-on-collision network handling with buffered, non-stalling command retirement. Sits between the network port and the core datapath (imem, reg file, PC register).

---
 rtl/net_cmd_unit_if.sv | 24 ++
 rtl/net_cmd_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/net_cmd_unit_if.sv
// Network packet port of net_cmd_unit: the master drives a packet, the slave
// reports whether it can take one this cycle.
interface net_cmd_unit_if #(
  parameter int ID_W   = 10,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              net_valid_i;
  logic [ID_W-1:0]   net_id_i;
  logic [2:0]        net_op_i;
  logic [ADDR_W-1:0] net_addr_i;
  logic [DATA_W-1:0] net_data_i;
  logic              net_ready_o;

  modport master (
    output net_valid_i, net_id_i, net_op_i, net_addr_i, net_data_i,
    input  net_ready_o
  );

  modport slave (
    input  net_valid_i, net_id_i, net_op_i, net_addr_i, net_data_i,
    output net_ready_o
  );
endinterface

// File: rtl/net_cmd_unit.sv
// Buffered network command front end: queues packets for this core and retires
// them in order as imem/RF writes, barrier updates or PC starts; owns run state.
// Optional macro NET_CMD_BYPASS_EN: retire straight from the port when empty.
module net_cmd_unit #(
  parameter int ID_W      = 10,
  parameter int NET_ID_P  = 1,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int INSTR_W   = 16,
  parameter int RF_ADDR_W = 6,
  parameter int MASK_W    = 3,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  net_cmd_unit_if.slave            net,
  input  logic                     core_stall_i,
  input  logic                     core_rf_busy_i,
  input  logic                     core_done_i,
  input  logic                     core_err_i,
  output logic                     imem_wen_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  output logic [INSTR_W-1:0]       imem_data_o,
  output logic                     rf_wen_o,
  output logic [RF_ADDR_W-1:0]     rf_addr_o,
  output logic [DATA_W-1:0]        rf_data_o,
  output logic                     pc_load_o,
  output logic [ADDR_W-1:0]        pc_load_addr_o,
  output logic [MASK_W-1:0]        barrier_init_o,
  output logic [MASK_W-1:0]        barrier_mask_o,
  output logic [1:0]               state_o,
  output logic                     exception_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  logic [2:0]        r_op_mem   [DEPTH];
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  state_t            w_state_next;
  logic [MASK_W-1:0] r_barrier_mask;
  logic              r_exception;

  logic              w_full;
  logic              w_empty;
  logic              w_op_known;
  logic              w_accept;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_src_valid;
  logic [2:0]        w_src_op;
  logic [ADDR_W-1:0] w_src_addr;
  logic [DATA_W-1:0] w_src_data;
  logic              w_src_can;
  logic              w_retire;
  logic              w_imem_wen;
  logic              w_rf_wen;
  logic              w_pc_load;
  logic              w_pc_fault;
  logic              w_bar_load;
  logic              w_exc_set;

  // In ERR every command is drained and discarded, so nothing ever blocks.
  function automatic logic f_can_retire(input logic [2:0] op, input state_t st,
                                        input logic stall, input logic rf_busy);
    logic ok;
    ok = 1'b1;
    if (st != ST_ERR) begin
      case (op)
        OP_INSTR: ok = (st != ST_RUN) || stall;
        OP_REG:   ok = !rf_busy;
        default:  ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_op_known = (net.net_op_i >= OP_INSTR) && (net.net_op_i <= OP_BAR);
  assign w_accept   = net.net_valid_i && (net.net_id_i == ID_W'(NET_ID_P)) &&
                      w_op_known && !w_full;
  assign net.net_ready_o = !w_full;

`ifdef NET_CMD_BYPASS_EN
  assign w_bypass = w_empty && w_accept &&
                    f_can_retire(net.net_op_i, r_state, core_stall_i, core_rf_busy_i);
`else
  assign w_bypass = 1'b0;
`endif

  // Head source is the FIFO, or the port itself when a bypass is taken.
  assign w_src_valid = reset && (!w_empty || w_bypass);
  assign w_src_op    = w_empty ? net.net_op_i   : r_op_mem[r_rd_ptr];
  assign w_src_addr  = w_empty ? net.net_addr_i : r_addr_mem[r_rd_ptr];
  assign w_src_data  = w_empty ? net.net_data_i : r_data_mem[r_rd_ptr];
  assign w_src_can   = f_can_retire(w_src_op, r_state, core_stall_i, core_rf_busy_i);
  assign w_retire    = w_src_valid && w_src_can;

  assign w_push = w_accept && !w_bypass;
  assign w_pop  = w_retire && !w_empty;

  always_comb begin
    w_state_next = r_state;
    w_imem_wen   = 1'b0;
    w_rf_wen     = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_fault   = 1'b0;
    w_bar_load   = 1'b0;
    w_exc_set    = 1'b0;
    if (w_retire && (r_state != ST_ERR)) begin
      case (w_src_op)
        OP_INSTR: w_imem_wen = 1'b1;
        OP_REG:   w_rf_wen   = 1'b1;
        OP_BAR:   w_bar_load = 1'b1;
        OP_PC: begin
          if (r_state == ST_IDLE) w_pc_load  = 1'b1;
          else                    w_pc_fault = 1'b1;
        end
        default: ;
      endcase
    end
    case (r_state)
      ST_IDLE: if (w_pc_load) w_state_next = ST_RUN;
      ST_RUN: begin
        // A fault outranks a DONE arriving in the same cycle.
        if (w_pc_fault || core_err_i) begin
          w_state_next = ST_ERR;
          w_exc_set    = 1'b1;
        end else if (core_done_i) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR:  w_state_next = ST_ERR;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_barrier_mask <= '0;
      r_exception    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_bar_load) r_barrier_mask <= w_src_data[MASK_W-1:0];
      if (w_exc_set)  r_exception    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]   <= net.net_op_i;
      r_addr_mem[r_wr_ptr] <= net.net_addr_i;
      r_data_mem[r_wr_ptr] <= net.net_data_i;
    end
  end

  assign imem_wen_o     = w_imem_wen;
  assign imem_addr_o    = w_src_addr;
  assign imem_data_o    = w_src_data[INSTR_W-1:0];
  assign rf_wen_o       = w_rf_wen;
  assign rf_addr_o      = w_src_addr[RF_ADDR_W-1:0];
  assign rf_data_o      = w_src_data;
  assign pc_load_o      = w_pc_load;
  assign pc_load_addr_o = w_src_addr;
  assign barrier_init_o = w_src_data[MASK_W-1:0];
  assign barrier_mask_o = r_barrier_mask;
  assign state_o        = r_state;
  assign exception_o    = r_exception;
  assign fifo_count_o   = r_count;

endmodule
